// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst beat generator: expands one AW/AR command into per-beat address, strobe, index and last.
// Optional macro AXI_BURST_ERR_CHECK_EN flags illegal bursts with SLVERR and zero strobes.
module axi_burst_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ADDR_W-1:0]     beat_addr_o,
    output logic [DATA_W/8-1:0]   beat_strb_o,
    output logic [7:0]            beat_idx_o,
    output logic                  beat_last_o,
    output logic [1:0]            beat_resp_o,
    output logic                  busy_o
);

    localparam int NB = DATA_W / 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // ~(S-1): clears the sub-beat offset bits of an address
    function automatic logic [ADDR_W-1:0] size_mask(input logic [2:0] size);
        return ~((ADDR_W'(1) << size) - ADDR_W'(1));
    endfunction

    function automatic logic [NB-1:0] lane_strb(input logic [ADDR_W-1:0] a,
                                                input logic [2:0]        size);
        logic [ADDR_W-1:0] lane_mask;
        logic [NB-1:0]     s;
        int                lo;
        int                hi;
        lane_mask = ADDR_W'(NB - 1);
        lo = int'(a & lane_mask);
        hi = int'(a & size_mask(size) & lane_mask) + (1 << size) - 1;
        if (hi > NB - 1) hi = NB - 1;
        for (int i = 0; i < NB; i++) begin
            s[i] = (i >= lo) && (i <= hi);
        end
        return s;
    endfunction

`ifdef AXI_BURST_ERR_CHECK_EN
    function automatic logic cmd_err(input logic [ADDR_W-1:0] addr,
                                     input logic [7:0]        len,
                                     input logic [2:0]        size,
                                     input logic [1:0]        burst);
        logic [ADDR_W-1:0] nbytes;
        logic [ADDR_W-1:0] last_byte;
        logic              err;
        nbytes    = (ADDR_W'(len) + ADDR_W'(1)) << size;
        last_byte = (addr & size_mask(size)) + nbytes - ADDR_W'(1);
        err = 1'b0;
        if ((1 << size) > NB) err = 1'b1;
        if (burst == BURST_WRAP && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15)
            err = 1'b1;
        if (burst == BURST_WRAP && (addr & ~size_mask(size)) != '0) err = 1'b1;
        // 4 KB page crossing: any differing bit above bit 11
        if (burst == BURST_INCR && ((addr ^ last_byte) >> 12) != '0) err = 1'b1;
        if (burst == 2'b11) err = 1'b1;
        return err;
    endfunction

    logic r_err;
`endif

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wrap_lower;
    logic [ADDR_W-1:0] r_wrap_end;
    logic [7:0]        r_idx;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic              w_busy;
    logic              w_last;
    logic              w_hs;
    logic              w_accept;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_cmd_wrap_bytes;
    logic [ADDR_W-1:0] w_cmd_lower;

    assign w_busy   = (r_state == S_BURST);
    assign w_last   = (r_idx == r_len);
    assign w_hs     = w_busy && beat_ready_i;
    assign w_accept = cmd_valid_i && cmd_ready_o;

    assign cmd_ready_o = !w_busy || (w_hs && w_last);

    assign w_cmd_wrap_bytes = (ADDR_W'(cmd_len_i) + ADDR_W'(1)) << cmd_size_i;
    assign w_cmd_lower      = cmd_addr_i & ~(w_cmd_wrap_bytes - ADDR_W'(1));

    // Next beat always steps from the aligned form of the current address
    assign w_step = (r_addr & size_mask(r_size)) + (ADDR_W'(1) << r_size);

    always_comb begin
        w_next_addr = w_step;
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  w_next_addr = (w_step == r_wrap_end) ? r_wrap_lower : w_step;
            default:     w_next_addr = w_step;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wrap_lower <= '0;
            r_wrap_end   <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
        end else if (w_accept) begin
            r_state      <= S_BURST;
            r_addr       <= cmd_addr_i;
            r_wrap_lower <= w_cmd_lower;
            r_wrap_end   <= w_cmd_lower + w_cmd_wrap_bytes;
            r_idx        <= '0;
            r_len        <= cmd_len_i;
            r_size       <= cmd_size_i;
            r_burst      <= cmd_burst_i;
        end else if (w_hs) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
            end else begin
                r_idx  <= r_idx + 8'd1;
                r_addr <= w_next_addr;
            end
        end
    end

`ifdef AXI_BURST_ERR_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= cmd_err(cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i);
        end
    end

    assign beat_strb_o = (w_busy && !r_err) ? lane_strb(r_addr, r_size) : '0;
    assign beat_resp_o = (w_busy && r_err) ? 2'b10 : 2'b00;
`else
    assign beat_strb_o = w_busy ? lane_strb(r_addr, r_size) : '0;
    assign beat_resp_o = 2'b00;
`endif

    assign beat_valid_o = w_busy;
    assign busy_o       = w_busy;
    assign beat_addr_o  = r_addr;
    assign beat_idx_o   = r_idx;
    assign beat_last_o  = w_busy && w_last;

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
- Sequential AXI4 burst beat generator that expands one AW/AR-style command into per-beat address, byte-strobe, index and last flag.
- Implements AXI4 FIXED, INCR and WRAP address rules for any parameterised address and data width.
- Sits behind master and slave BFMs and the crossbar scoreboard as the common beat-sequencing engine.
- Successor to the static burst type/size/response definitions: it adds actual burst sequencing and protocol-error detection.

Parameters:
- ADDR_W, 32, address width in bits; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 64, data bus width in bits; power of two, 8..1024; NB = DATA_W/8 byte lanes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_addr_i  in  ADDR_W  burst start address; may be unaligned.
- cmd_len_i  in  8  AxLEN; beats = len+1.
- cmd_size_i  in  3  AxSIZE; bytes/beat = 2^size.
- cmd_burst_i  in  2  AxBURST: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid_o  out  1  beat valid.
- beat_ready_i  in  1  beat ready.
- beat_addr_o  out  ADDR_W  beat address.
- beat_strb_o  out  NB  active byte lanes.
- beat_idx_o  out  8  beat number, 0..len.
- beat_last_o  out  1  final beat of the burst.
- beat_resp_o  out  2  00 OKAY, 10 SLVERR.
- busy_o  out  1  burst in progress.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: beat_valid_o=0, beat_last_o=0, beat_idx_o=0, beat_addr_o=0, beat_strb_o=0, beat_resp_o=00, busy_o=0, state=IDLE.
- States: IDLE and BURST.
- cmd_ready_o = (state==IDLE) || (beat_valid_o && beat_ready_i && beat_last_o). It is combinational and reads 1 in IDLE, including while in reset.
- Accept: cmd_valid_i && cmd_ready_o latches the command. The FSM enters BURST and beat 0 is valid the next cycle, so latency is 1.
- Back-to-back: a new command accepted on the last-beat handshake gives the first beat of the new burst the following cycle, with no bubble.
- Beat advance: on beat_valid_o && beat_ready_i, beat_idx_o increments.
  - On the last beat, go to IDLE, or stay in BURST if a new command was accepted in the same cycle.
- Hold: while beat_valid_o && !beat_ready_i, all beat_* outputs hold stable.
- Beat 0 address is always cmd_addr_i.
- Address rules for beat n>0, with S = 2^size and aligned = addr & ~(S-1):
  - FIXED: every beat address = cmd_addr_i.
  - INCR: aligned + n*S, truncated to ADDR_W bits.
  - WRAP: wrap_bytes = (len+1)*S and lower = addr & ~(wrap_bytes-1).
    - next = prev_aligned + S; if next == lower + wrap_bytes then next = lower.
- Strobe for beat address A: lanes (A mod NB) through ((A & ~(S-1)) mod NB) + S - 1 are set; all other lanes are 0. If S >= NB, lanes from (A mod NB) to NB-1 are set.
- beat_last_o = (beat_idx_o == len).
- Reserved burst type 11 sequences as INCR.
- busy_o = (state==BURST).
- Reset asserted mid-burst: the burst is abandoned and outputs go to their reset values immediately. After release the block is in IDLE; no partial-burst state is retained.

Optional Feature:
- Macro AXI_BURST_ERR_CHECK_EN.
- When defined, each command is checked on acceptance. beat_resp_o=10 on every beat of the burst, and beat_strb_o all 0, if any of the following holds:
  - S > NB;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address;
  - INCR with the last byte in a different 4 KB page from the first;
  - burst type 11.
- Errored bursts still emit exactly len+1 beats with normal addresses and last.
- When undefined, beat_resp_o is constant 00, no checks are performed and the strobes follow the rules above.

Test Plan:
- DATA_W=32, INCR addr 0x1002, len 3, size 2 -> addresses 0x1002, 0x1004, 0x1008, 0x100C; strb 1100, 1111, 1111, 1111; last only on idx 3; first beat 1 cycle after accept.
- WRAP addr 0x34, len 3, size 2 -> addresses 0x34, 0x38, 0x3C, 0x30; strb 1111 each; resp 00.
- FIXED addr 0x101, len 2, size 0 -> addr 0x101 three times, strb 0010 each, idx 0..2.
- INCR len 7 with beat_ready_i low for 3 cycles at idx 2 -> outputs held stable; second command presented early is accepted on the last handshake and its idx 0 appears the next cycle.
- With AXI_BURST_ERR_CHECK_EN: INCR addr 0xFF8, len 3, size 2 -> 4 beats, resp 10, strb 0000.
  - Without the macro: addresses 0xFF8, 0xFFC, 0x1000, 0x1004, resp 00.
- rst_ni low after idx 1 handshake -> beat_valid_o=0 and busy_o=0 with no clock edge; after release cmd_ready_o=1 and a new burst starts at idx 0.
